// File: rtl/fir_lpf_mac.sv
// Time-multiplexed FIR low-pass filter for the ECG front end.
// One MAC is reused over TAPS cycles; the result is rounded and saturated.
module fir_lpf_mac #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int SHIFT  = 15,
  parameter int AW     = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] out_ecg,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_err,
  output logic signed [DATA_W-1:0] filtered_ecg,
  output logic                     out_valid
);

  localparam int ACC_W = DATA_W + COEF_W + AW;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  localparam logic signed [COEF_W-1:0] C0 =
    (SHIFT >= COEF_W - 1) ? {1'b0, {(COEF_W-1){1'b1}}}
                          : COEF_W'((1 << SHIFT) - 1);

  localparam logic signed [ACC_W:0] HALF =
    {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_W:0] MAXV =
    {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV =
    {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t state, state_d;

  logic signed [DATA_W-1:0] x    [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [AW-1:0]            idx;

  logic                     accept;
  logic                     wr_ok;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W:0]    rnd;
  logic signed [ACC_W:0]    shr;
  logic signed [DATA_W-1:0] sat;

  assign in_ready = reset & enable & (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign wr_ok    = coef_we & enable & (state == IDLE);

  assign prod = coef[idx] * x[idx];
  // one guard bit so the rounding add cannot wrap
  assign rnd  = {acc[ACC_W-1], acc} + HALF;
  assign shr  = rnd >>> SHIFT;

  always_comb begin
    sat = shr[DATA_W-1:0];
    if (shr > MAXV) sat = MAXV[DATA_W-1:0];
    else if (shr < MINV) sat = MINV[DATA_W-1:0];
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (accept) state_d = MAC;
      MAC:  if (enable && idx == LAST) state_d = OUT;
      OUT:  if (enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      acc          <= '0;
      idx          <= '0;
      filtered_ecg <= '0;
      out_valid    <= 1'b0;
      coef_err     <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x[k]    <= '0;
        coef[k] <= (k == 0) ? C0 : '0;
      end
    end else begin
      state     <= state_d;
      out_valid <= enable && (state == OUT);
      coef_err  <= coef_we && !wr_ok;
      if (wr_ok) coef[coef_addr] <= coef_data;
      if (accept) begin
        x[0] <= out_ecg;
        for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
        acc <= '0;
        idx <= '0;
      end
      if (enable && state == MAC) begin
        acc <= acc + {{AW{prod[PROD_W-1]}}, prod};
        idx <= (idx == LAST) ? '0 : idx + 1'b1;
      end
      if (enable && state == OUT) filtered_ecg <= sat;
    end
  end

endmodule
